// File: rtl/m_bus_mst_pkg.sv
// Shared constants, error codes and FSM states for the M-bus poll master.
package m_bus_mst_pkg;

  localparam logic [7:0]  CMD_POLL = 8'h01;
  localparam logic [7:0]  RSP_FLAG = 8'h80;
  localparam logic [1:0]  CRC_OK   = 2'b01;
  localparam int          HDR_LEN  = 4;
  localparam logic [10:0] REQ_LEN  = 11'd4;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_TIMEOUT = 3'd1;
  localparam logic [2:0] ERR_CRC     = 3'd2;
  localparam logic [2:0] ERR_ADDR    = 3'd3;
  localparam logic [2:0] ERR_CMD     = 3'd4;
  localparam logic [2:0] ERR_SEQ     = 3'd5;
  localparam logic [2:0] ERR_LEN     = 3'd6;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_BUILD   = 4'd1,
    S_START   = 4'd2,
    S_WAIT_RX = 4'd3,
    S_HDR     = 4'd4,
    S_COPY    = 4'd5,
    S_OK      = 4'd6,
    S_FAIL    = 4'd7,
    S_NEXT    = 4'd8
  } state_e;

endpackage

// File: rtl/m_bus_mst_rsp_chk.sv
// Response header checker: judges one header byte per cycle and keeps the payload length.
module m_bus_mst_rsp_chk
  import m_bus_mst_pkg::*;
#(
  parameter int RSP_MAX_LEN = 240
) (
  input  logic       clk,
  input  logic       chk_en_i,
  input  logic [1:0] idx_i,
  input  logic [7:0] rdata_i,
  input  logic [7:0] exp_addr_i,
  input  logic [7:0] exp_seq_i,
  output logic       pass_o,
  output logic [2:0] err_code_o,
  output logic [7:0] rsp_len_o
);

  logic [7:0] rsp_len_q;

  always_comb begin
    pass_o     = 1'b1;
    err_code_o = ERR_NONE;
    if (chk_en_i) begin
      unique case (idx_i)
        2'd0: if (rdata_i != exp_addr_i) begin
          pass_o     = 1'b0;
          err_code_o = ERR_ADDR;
        end
        2'd1: if (rdata_i != (RSP_FLAG | CMD_POLL)) begin
          pass_o     = 1'b0;
          err_code_o = ERR_CMD;
        end
        2'd2: if (rdata_i != exp_seq_i) begin
          pass_o     = 1'b0;
          err_code_o = ERR_SEQ;
        end
        default: if (32'(rdata_i) > 32'(RSP_MAX_LEN)) begin
          pass_o     = 1'b0;
          err_code_o = ERR_LEN;
        end
      endcase
    end
  end

  // Length is pure data; it is always rewritten before COPY consumes it.
  always_ff @(posedge clk) begin
    if (chk_en_i && idx_i == 2'd3) rsp_len_q <= rdata_i;
  end

  assign rsp_len_o = rsp_len_q;

endmodule

// File: rtl/m_bus_master_poll.sv
// M-bus control-station poll master: cycles through the slots of one rack,
// sends a 4-byte poll, validates the reply and copies its payload upstream.
module m_bus_master_poll
  import m_bus_mst_pkg::*;
#(
  parameter int SLOT_NUM    = 10,
  parameter int TIMEOUT     = 20000,
  parameter int SLOT_STRIDE = 256,
  parameter int RSP_MAX_LEN = 240
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [2:0]          rack_id,
  output logic                tx_buf_wren,
  output logic [10:0]         tx_buf_waddr,
  output logic [7:0]          tx_buf_wdata,
  output logic [10:0]         tx_data_len,
  output logic                tx_start,
  input  logic                rx_start,
  input  logic                rx_done,
  input  logic [1:0]          rx_crc_rslt,
  output logic                rx_buf_rden,
  output logic [10:0]         rx_buf_raddr,
  input  logic [7:0]          rx_buf_rdata,
  output logic                ud_wren,
  output logic [23:0]         ud_waddr,
  output logic [7:0]          ud_wdata,
  output logic [SLOT_NUM-1:0] slot_ok,
  output logic                cycle_done,
  output logic                err_pulse,
  output logic [2:0]          err_code
);

  localparam int         TO_W      = $clog2(TIMEOUT + 1);
  localparam logic [3:0] SLOT_LAST = 4'(SLOT_NUM - 1);

  state_e              state_q, state_d;
  logic [8:0]          idx_q, idx_d;
  logic [TO_W-1:0]     to_q, to_d;
  logic [3:0]          slot_q, slot_d;
  logic [7:0]          seq_q, seq_d;
  logic [SLOT_NUM-1:0] slot_ok_q, slot_ok_d;
  logic [2:0]          err_code_q, err_code_d;
  logic                len_set_q, len_set_d;

  logic [SLOT_NUM-1:0] slot_mask;
  logic [7:0]          addr_byte;
  logic                chk_en, chk_pass;
  logic [2:0]          chk_err;
  logic [7:0]          rsp_len;
  logic                hdr_rd, copy_rd;
  logic                unused_rx_start;

  assign unused_rx_start = rx_start;
  assign addr_byte       = {1'b0, rack_id, slot_q};
  assign chk_en          = (state_q == S_HDR) && (idx_q != 9'd0);

  always_comb begin
    for (int i = 0; i < SLOT_NUM; i++) slot_mask[i] = (slot_q == 4'(i));
  end

  m_bus_mst_rsp_chk #(
    .RSP_MAX_LEN(RSP_MAX_LEN)
  ) u_rsp_chk (
    .clk       (clk),
    .chk_en_i  (chk_en),
    .idx_i     (idx_q[1:0] - 2'd1),
    .rdata_i   (rx_buf_rdata),
    .exp_addr_i(addr_byte),
    .exp_seq_i (seq_q),
    .pass_o    (chk_pass),
    .err_code_o(chk_err),
    .rsp_len_o (rsp_len)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    to_d       = to_q;
    slot_d     = slot_q;
    seq_d      = seq_q;
    slot_ok_d  = slot_ok_q;
    err_code_d = err_code_q;
    len_set_d  = len_set_q | (state_q == S_BUILD);
    unique case (state_q)
      S_IDLE: if (en) begin
        state_d = S_BUILD;
        idx_d   = '0;
      end
      S_BUILD: begin
        idx_d = idx_q + 9'd1;
        if (idx_q == 9'd3) state_d = S_START;
      end
      S_START: begin
        to_d    = '0;
        state_d = S_WAIT_RX;
      end
      S_WAIT_RX: begin
        to_d = to_q + TO_W'(1);
        // A reply landing on the timeout cycle still counts.
        if (rx_done) begin
          if (rx_crc_rslt == CRC_OK) begin
            state_d = S_HDR;
            idx_d   = '0;
          end else begin
            state_d    = S_FAIL;
            err_code_d = ERR_CRC;
          end
        end else if (to_q == TO_W'(TIMEOUT - 2)) begin
          state_d    = S_FAIL;
          err_code_d = ERR_TIMEOUT;
        end
      end
      S_HDR: begin
        idx_d = idx_q + 9'd1;
        if (idx_q != 9'd0) begin
          if (!chk_pass) begin
            state_d    = S_FAIL;
            err_code_d = chk_err;
          end else if (idx_q == 9'(HDR_LEN)) begin
            state_d = (rx_buf_rdata == 8'd0) ? S_OK : S_COPY;
            idx_d   = '0;
          end
        end
      end
      S_COPY: begin
        idx_d = idx_q + 9'd1;
        if (idx_q == {1'b0, rsp_len}) state_d = S_OK;
      end
      S_OK: begin
        slot_ok_d = slot_ok_q | slot_mask;
        state_d   = S_NEXT;
      end
      S_FAIL: begin
        slot_ok_d = slot_ok_q & ~slot_mask;
        state_d   = S_NEXT;
      end
      S_NEXT: begin
        seq_d   = seq_q + 8'd1;
        slot_d  = (slot_q == SLOT_LAST) ? 4'd0 : slot_q + 4'd1;
        idx_d   = '0;
        state_d = en ? S_BUILD : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      to_q       <= '0;
      slot_q     <= '0;
      seq_q      <= '0;
      slot_ok_q  <= '0;
      err_code_q <= ERR_NONE;
      len_set_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      to_q       <= to_d;
      slot_q     <= slot_d;
      seq_q      <= seq_d;
      slot_ok_q  <= slot_ok_d;
      err_code_q <= err_code_d;
      len_set_q  <= len_set_d;
    end
  end

  // Outputs decode straight from state so an async reset silences them at once.
  assign tx_buf_wren  = (state_q == S_BUILD);
  assign tx_buf_waddr = tx_buf_wren ? 11'(idx_q) : 11'd0;
  assign tx_data_len  = (len_set_q || tx_buf_wren) ? REQ_LEN : 11'd0;
  assign tx_start     = (state_q == S_START);

  always_comb begin
    tx_buf_wdata = 8'h00;
    if (tx_buf_wren) begin
      unique case (idx_q[1:0])
        2'd0:    tx_buf_wdata = addr_byte;
        2'd1:    tx_buf_wdata = CMD_POLL;
        2'd2:    tx_buf_wdata = seq_q;
        default: tx_buf_wdata = 8'h00;
      endcase
    end
  end

  assign hdr_rd       = (state_q == S_HDR) && (idx_q < 9'(HDR_LEN));
  assign copy_rd      = (state_q == S_COPY) && (idx_q < {1'b0, rsp_len});
  assign rx_buf_rden  = hdr_rd | copy_rd;
  assign rx_buf_raddr = hdr_rd  ? 11'(idx_q) :
                        copy_rd ? 11'(idx_q) + 11'(HDR_LEN) : 11'd0;

  assign ud_wren  = (state_q == S_COPY) && (idx_q != 9'd0);
  assign ud_waddr = ud_wren ? 24'(slot_q) * 24'(SLOT_STRIDE) + 24'(idx_q - 9'd1) : 24'd0;
  assign ud_wdata = ud_wren ? rx_buf_rdata : 8'h00;

  assign slot_ok    = slot_ok_q;
  assign cycle_done = (state_q == S_NEXT) && (slot_q == SLOT_LAST);
  assign err_pulse  = (state_q == S_FAIL);
  assign err_code   = err_code_q;

endmodule

// File: tb/tb_m_bus_master_poll.sv
// Bench for m_bus_master_poll: plays the link/card side with random replies
// and compares every poll against a transaction-level model.
module tb_m_bus_master_poll;

  localparam int SLOT_NUM    = 2;
  localparam int TIMEOUT     = 100;
  localparam int SLOT_STRIDE = 256;
  localparam int RSP_MAX_LEN = 240;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset, en, rx_start, rx_done;
  logic [2:0]          rack_id;
  logic [1:0]          rx_crc_rslt;
  logic                tx_buf_wren, tx_start, rx_buf_rden, ud_wren, cycle_done, err_pulse;
  logic [10:0]         tx_buf_waddr, tx_data_len, rx_buf_raddr;
  logic [7:0]          tx_buf_wdata, rx_buf_rdata, ud_wdata;
  logic [23:0]         ud_waddr;
  logic [SLOT_NUM-1:0] slot_ok;
  logic [2:0]          err_code;

  m_bus_master_poll #(
    .SLOT_NUM(SLOT_NUM), .TIMEOUT(TIMEOUT), .SLOT_STRIDE(SLOT_STRIDE), .RSP_MAX_LEN(RSP_MAX_LEN)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .rack_id(rack_id),
    .tx_buf_wren(tx_buf_wren), .tx_buf_waddr(tx_buf_waddr), .tx_buf_wdata(tx_buf_wdata),
    .tx_data_len(tx_data_len), .tx_start(tx_start),
    .rx_start(rx_start), .rx_done(rx_done), .rx_crc_rslt(rx_crc_rslt),
    .rx_buf_rden(rx_buf_rden), .rx_buf_raddr(rx_buf_raddr), .rx_buf_rdata(rx_buf_rdata),
    .ud_wren(ud_wren), .ud_waddr(ud_waddr), .ud_wdata(ud_wdata),
    .slot_ok(slot_ok), .cycle_done(cycle_done), .err_pulse(err_pulse), .err_code(err_code)
  );

  // RX buffer model: one-cycle read latency.
  logic [7:0] rx_mem [0:2047];
  logic [7:0] rx_q;
  always @(posedge clk) if (rx_buf_rden) rx_q <= rx_mem[rx_buf_raddr];
  assign rx_buf_rdata = rx_q;

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor: per-poll activity, rolled over at every tx_start.
  int            cyc = 0, start_cnt = 0, start_cyc = 0, prev_start_cyc = 0;
  logic [7:0]    tx_mem [4];
  logic [7:0]    req [4];
  logic [10:0]   req_len;
  logic [2:0]    start_ec;
  logic [31:0]   acc_ud[$], prev_ud[$];
  int            acc_rd = 0, acc_err = 0, acc_err_cyc = 0, acc_cd = 0;
  int            prev_rd = 0, prev_err = 0, prev_err_cyc = 0, prev_cd = 0;
  logic [2:0]    acc_code = 0, prev_code = 0;
  logic [SLOT_NUM-1:0] prev_slot_ok;

  initial forever begin
    @(negedge clk);
    cyc++;
    if (reset) begin
      acc_ud.delete();
      acc_rd = 0; acc_err = 0; acc_cd = 0;
    end else begin
      if (tx_buf_wren && tx_buf_waddr < 11'd4) tx_mem[tx_buf_waddr[1:0]] = tx_buf_wdata;
      if (ud_wren) acc_ud.push_back({ud_waddr, ud_wdata});
      if (rx_buf_rden) acc_rd++;
      if (err_pulse) begin acc_err++; acc_code = err_code; acc_err_cyc = cyc; end
      if (cycle_done) acc_cd++;
      if (tx_start) begin
        prev_ud = acc_ud; acc_ud.delete();
        prev_rd = acc_rd; prev_err = acc_err; prev_err_cyc = acc_err_cyc;
        prev_code = acc_code; prev_cd = acc_cd;
        acc_rd = 0; acc_err = 0; acc_cd = 0;
        prev_start_cyc = start_cyc; start_cyc = cyc;
        for (int i = 0; i < 4; i++) req[i] = tx_mem[i];
        req_len = tx_data_len; start_ec = err_code; prev_slot_ok = slot_ok;
        start_cnt++;
      end
    end
  end

  // Reference model
  logic [3:0]          slot_m;
  logic [7:0]          seq_m;
  logic [SLOT_NUM-1:0] ok_m;
  logic [2:0]          code_m;
  logic [3:0]          pend_slot;
  logic [2:0]          pend_code;
  logic [7:0]          pend_pay[$];
  bit                  have_prev;
  int                  seen = 0;

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic model_reset();
    slot_m = 0; seq_m = 0; ok_m = '0; code_m = 0; have_prev = 0;
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_wren"}, tx_buf_wren, 0);
    check_val({tag, "_waddr"}, tx_buf_waddr, 0);
    check_val({tag, "_wdata"}, tx_buf_wdata, 0);
    check_val({tag, "_len"}, tx_data_len, 0);
    check_val({tag, "_txs"}, tx_start, 0);
    check_val({tag, "_rden"}, rx_buf_rden, 0);
    check_val({tag, "_raddr"}, rx_buf_raddr, 0);
    check_val({tag, "_udw"}, ud_wren, 0);
    check_val({tag, "_uda"}, ud_waddr, 0);
    check_val({tag, "_udd"}, ud_wdata, 0);
    check_val({tag, "_ok"}, slot_ok, 0);
    check_val({tag, "_cd"}, cycle_done, 0);
    check_val({tag, "_ep"}, err_pulse, 0);
    check_val({tag, "_ec"}, err_code, 0);
  endtask

  task automatic wait_start(output bit ok);
    int n = 0;
    while (start_cnt <= seen && n < 2000) begin tick(); n++; end
    check_val("start_cnt", start_cnt, seen + 1);
    ok = (start_cnt == seen + 1);
    seen = start_cnt;
  endtask

  task automatic check_prev();
    int n;
    if (!have_prev) return;
    check_val("err_pulses", prev_err, 32'(pend_code != 0));
    if (pend_code != 0) check_val("err_code", prev_code, pend_code);
    if (pend_code == 3'd1) check_val("to_latency", prev_err_cyc - prev_start_cyc, TIMEOUT);
    if (pend_code == 0) check_val("rden_cnt", prev_rd, 4 + pend_pay.size());
    if (pend_code == 3'd1 || pend_code == 3'd2) check_val("rden_none", prev_rd, 0);
    check_val("ud_count", prev_ud.size(), pend_pay.size());
    n = (prev_ud.size() < pend_pay.size()) ? prev_ud.size() : pend_pay.size();
    for (int k = 0; k < n; k++) begin
      check_val("ud_addr", prev_ud[k][31:8], pend_slot * SLOT_STRIDE + k);
      check_val("ud_data", prev_ud[k][7:0], pend_pay[k]);
    end
    check_val("slot_ok", prev_slot_ok, ok_m);
    check_val("cycle_done", prev_cd, 32'(pend_slot == 4'(SLOT_NUM - 1)));
  endtask

  task automatic check_req();
    check_val("req_addr", req[0], {1'b0, rack_id, slot_m});
    check_val("req_cmd", req[1], 8'h01);
    check_val("req_seq", req[2], seq_m);
    check_val("req_pad", req[3], 8'h00);
    check_val("req_len", req_len, 4);
    check_val("err_hold", start_ec, code_m);
  endtask

  // kind: 0-7 good, 8 N=240, 9 crc, 10 timeout, 11 addr, 12 cmd, 13 seq,
  // 14 len, 15 rx_done on timeout cycle, 16 AA BB CC, 17 N=8.
  task automatic respond(input int forced);
    int kind, n, d;
    logic [7:0] h0, h1, h2, b;
    logic [1:0] crc;
    kind = (forced >= 0) ? forced : $urandom_range(0, 15);
    pend_slot = slot_m; pend_pay.delete(); pend_code = 0;
    d = $urandom_range(1, 40);
    h0 = {1'b0, rack_id, slot_m}; h1 = 8'h81; h2 = seq_m;
    n = $urandom_range(0, 6);
    crc = 2'b01;
    case (kind)
      8:  n = RSP_MAX_LEN;
      9:  begin crc = 2'($urandom_range(0, 2)); if (crc == 2'b01) crc = 2'b11; pend_code = 2; end
      10: pend_code = 1;
      11: begin b = 8'h01 << $urandom_range(0, 7); h0 = h0 ^ b; pend_code = 3; end
      12: begin b = 8'h01 << $urandom_range(0, 7); h1 = h1 ^ b; pend_code = 4; end
      13: begin h2 = seq_m + 8'd1; pend_code = 5; end
      14: begin n = $urandom_range(RSP_MAX_LEN + 1, 255); pend_code = 6; end
      15: d = TIMEOUT - 1;
      16: n = 3;
      17: n = 8;
      default: ;
    endcase
    rx_mem[0] = h0; rx_mem[1] = h1; rx_mem[2] = h2; rx_mem[3] = 8'(n);
    for (int k = 0; k < n; k++) begin
      b = (kind == 16) ? 8'hAA + 8'(k * 17) : 8'($urandom_range(0, 255));
      rx_mem[4 + k] = b;
      if (pend_code == 0) pend_pay.push_back(b);
    end
    if (pend_code == 0) ok_m[int'(slot_m)] = 1'b1;
    else begin ok_m[int'(slot_m)] = 1'b0; code_m = pend_code; end
    slot_m = (slot_m == 4'(SLOT_NUM - 1)) ? 4'd0 : slot_m + 4'd1;
    seq_m = seq_m + 8'd1;
    have_prev = 1;
    if (kind != 10) begin
      while (cyc < start_cyc + d) tick();
      rx_done = 1'b1; rx_crc_rslt = crc;
      tick();
      rx_done = 1'b0; rx_crc_rslt = 2'b00;
    end
  endtask

  task automatic run_polls(input int cnt, input int nforce);
    bit ok;
    for (int i = 0; i < cnt; i++) begin
      wait_start(ok);
      if (!ok) return;
      check_prev();
      check_req();
      respond(i < nforce ? 16 : -1);
    end
  endtask

  task automatic reset_in_copy();
    bit ok;
    int n = 0;
    wait_start(ok);
    if (!ok) return;
    check_prev();
    check_req();
    respond(17);
    while (!ud_wren && n < 60) begin tick(); n++; end
    check_val("copy_reached", ud_wren, 1);
    tick();
    reset = 1'b1;
    #1;
    check_zero("rst_copy");
    repeat (3) tick();
    check_zero("rst_hold");
    reset = 1'b0;
    model_reset();
    rack_id = 3'd5;
  endtask

  initial begin
    bit ok;
    reset = 1'b1; en = 1'b0; rack_id = 3'd3;
    rx_start = 1'b0; rx_done = 1'b0; rx_crc_rslt = 2'b00;
    tick(); tick();
    check_zero("por");
    reset = 1'b0;
    repeat (10) tick();
    check_val("idle_no_start", start_cnt, 0);
    check_val("idle_len", tx_data_len, 0);
    model_reset();
    en = 1'b1;
    run_polls(300, 2);
    reset_in_copy();
    run_polls(8, 0);
    wait_start(ok);
    if (ok) check_prev();
    en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
